// File: rtl/wshb_arb_pkg.sv
// Shared types and helpers for the two-master Wishbone arbiter.
package wshb_arb_pkg;

  localparam int NB_MASTERS = 2;

  typedef enum logic [1:0] {
    IDLE,
    GRANT0,
    GRANT1
  } arb_state_t;

  // Round-robin choice between the requesters: a lone requester wins,
  // and when both ask the one that was not served last wins.
  function automatic logic rr_pick(input logic [NB_MASTERS-1:0] req, input logic last);
    logic pick;
    pick = 1'b0;
    case (req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last;
      default: pick = 1'b0;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/wshb_arbiter2.sv
// Two-master, one-slave round-robin arbiter for the shared 16-bit Wishbone
// bus in front of the SDRAM controller. A grant is taken at Wishbone-cycle
// granularity and held until the owning master drops cyc, so bursts are never
// split. The grant itself is registered; the bus muxes are combinational.
module wshb_arbiter2
  import wshb_arb_pkg::*;
#(
  parameter int ADR_W      = 32,
  parameter int DATA_BYTES = 2
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic                      m0_cyc,
  input  logic                      m0_stb,
  input  logic                      m0_we,
  input  logic [ADR_W-1:0]          m0_adr,
  input  logic [8*DATA_BYTES-1:0]   m0_dat_ms,
  input  logic [DATA_BYTES-1:0]     m0_sel,
  input  logic [2:0]                m0_cti,
  input  logic [1:0]                m0_bte,
  output logic [8*DATA_BYTES-1:0]   m0_dat_sm,
  output logic                      m0_ack,

  input  logic                      m1_cyc,
  input  logic                      m1_stb,
  input  logic                      m1_we,
  input  logic [ADR_W-1:0]          m1_adr,
  input  logic [8*DATA_BYTES-1:0]   m1_dat_ms,
  input  logic [DATA_BYTES-1:0]     m1_sel,
  input  logic [2:0]                m1_cti,
  input  logic [1:0]                m1_bte,
  output logic [8*DATA_BYTES-1:0]   m1_dat_sm,
  output logic                      m1_ack,

  output logic                      s_cyc,
  output logic                      s_stb,
  output logic                      s_we,
  output logic [ADR_W-1:0]          s_adr,
  output logic [8*DATA_BYTES-1:0]   s_dat_ms,
  output logic [DATA_BYTES-1:0]     s_sel,
  output logic [2:0]                s_cti,
  output logic [1:0]                s_bte,
  input  logic [8*DATA_BYTES-1:0]   s_dat_sm,
  input  logic                      s_ack,

  output logic [1:0]                gnt
);

  arb_state_t state;
  logic       last;

  // Grant state machine: picks an owner from IDLE, holds it while cyc stays
  // high, and hands straight over to a waiting master when the owner lets go.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      gnt   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (m0_cyc || m1_cyc) begin
            if (rr_pick({m1_cyc, m0_cyc}, last)) begin
              state <= GRANT1;
              gnt   <= 2'b10;
            end else begin
              state <= GRANT0;
              gnt   <= 2'b01;
            end
          end
        end
        GRANT0: begin
          if (!m0_cyc) begin
            last <= 1'b0;
            if (m1_cyc) begin
              state <= GRANT1;
              gnt   <= 2'b10;
            end else begin
              state <= IDLE;
              gnt   <= 2'b00;
            end
          end
        end
        GRANT1: begin
          if (!m1_cyc) begin
            last <= 1'b1;
            if (m0_cyc) begin
              state <= GRANT0;
              gnt   <= 2'b01;
            end else begin
              state <= IDLE;
              gnt   <= 2'b00;
            end
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 2'b00;
        end
      endcase
    end
  end

  // Bus steering: the owner's signals go to the slave and only the owner sees
  // ack; read data is broadcast since ack is what qualifies it.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_ms = '0;
    s_sel    = '0;
    s_cti    = 3'b000;
    s_bte    = 2'b00;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    m0_dat_sm = s_dat_sm;
    m1_dat_sm = s_dat_sm;
    case (state)
      GRANT0: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_dat_ms = m0_dat_ms;
        s_sel    = m0_sel;
        s_cti    = m0_cti;
        s_bte    = m0_bte;
        m0_ack   = s_ack;
      end
      GRANT1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_ms = m1_dat_ms;
        s_sel    = m1_sel;
        s_cti    = m1_cti;
        s_bte    = m1_bte;
        m1_ack   = s_ack;
      end
      default: begin
        s_cyc = 1'b0;
        s_stb = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_wshb_arbiter2.sv
// Testbench for wshb_arbiter2: two master drivers, a slave model with
// configurable wait states, and a monitor that checks grants against a
// round-robin reference and pops a per-master scoreboard on every ack.
module tb_wshb_arbiter2;

  localparam int TIMEOUT = 300;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [15:0] dat;
    logic [1:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;

  logic        mcyc [2];
  logic        mstb [2];
  logic        mwe  [2];
  logic [31:0] madr [2];
  logic [15:0] mdat [2];
  logic [1:0]  msel [2];
  logic [2:0]  mcti [2];
  logic [1:0]  mbte [2];

  logic [15:0] m0_dat_sm, m1_dat_sm;
  logic        m0_ack, m1_ack;

  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr;
  logic [15:0] s_dat_ms;
  logic [1:0]  s_sel;
  logic [2:0]  s_cti;
  logic [1:0]  s_bte;
  logic [15:0] s_dat_sm = 16'h0000;
  logic        s_ack = 1'b0;
  logic [1:0]  gnt;

  int checks = 0;
  int errors = 0;

  beat_t q0[$];
  beat_t q1[$];
  int    glog[$];
  int    alog[$];
  int    ack_cnt[2];
  logic [15:0] last_rd[2];

  int   slv_min = 0;
  int   slv_max = 0;
  logic slv_hold = 1'b0;
  logic slv_spurious = 1'b0;
  logic slv_busy = 1'b0;
  int   slv_wait = 0;

  wshb_arbiter2 #(.ADR_W(32), .DATA_BYTES(2)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(mcyc[0]), .m0_stb(mstb[0]), .m0_we(mwe[0]), .m0_adr(madr[0]),
    .m0_dat_ms(mdat[0]), .m0_sel(msel[0]), .m0_cti(mcti[0]), .m0_bte(mbte[0]),
    .m0_dat_sm(m0_dat_sm), .m0_ack(m0_ack),
    .m1_cyc(mcyc[1]), .m1_stb(mstb[1]), .m1_we(mwe[1]), .m1_adr(madr[1]),
    .m1_dat_ms(mdat[1]), .m1_sel(msel[1]), .m1_cti(mcti[1]), .m1_bte(mbte[1]),
    .m1_dat_sm(m1_dat_sm), .m1_ack(m1_ack),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
    .s_dat_sm(s_dat_sm), .s_ack(s_ack),
    .gnt(gnt)
  );

  // Free-running bus clock.
  always #5 clk = ~clk;

  function automatic logic [15:0] slave_data(input logic [31:0] a);
    return a[15:0] ^ 16'hBFEF;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One Wishbone cycle from master m: nbeats beats, burst or classic.
  task automatic applyStimulus(input int m, input logic [31:0] adr, input int nbeats,
                               input logic burst, input logic we);
    beat_t bt;
    logic  got;
    for (int b = 0; b < nbeats; b++) begin
      bt.adr = adr + 32'(2 * b);
      bt.we  = we;
      bt.dat = 16'($urandom);
      bt.sel = 2'($urandom_range(3, 1));
      bt.cti = burst ? ((b == nbeats - 1) ? 3'b111 : 3'b010) : 3'b000;
      bt.bte = 2'b00;
      mcyc[m] = 1'b1; mstb[m] = 1'b1; mwe[m] = bt.we; madr[m] = bt.adr;
      mdat[m] = bt.dat; msel[m] = bt.sel; mcti[m] = bt.cti; mbte[m] = bt.bte;
      if (m == 0) q0.push_back(bt);
      else        q1.push_back(bt);
      got = 1'b0;
      for (int t = 0; t < TIMEOUT && !got; t++) begin
        @(negedge clk);
        if ((m == 0) ? m0_ack : m1_ack) got = 1'b1;
        else begin
          @(posedge clk);
          #1;
        end
      end
      if (!got) begin
        checks++;
        errors++;
        $display("[TB] FAIL ack_timeout_m%0d: actual=no ack in %0d cycles required=ack", m, TIMEOUT);
        mcyc[m] = 1'b0; mstb[m] = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    mcyc[m] = 1'b0; mstb[m] = 1'b0; mwe[m] = 1'b0; mcti[m] = 3'b000;
    tick(1);
  endtask

  task automatic popBeat(input int m, input logic [15:0] rd);
    beat_t bt;
    if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
      checks++;
      errors++;
      $display("[TB] FAIL sb_empty_m%0d: actual=ack required=no outstanding beat", m);
      return;
    end
    if (m == 0) bt = q0.pop_front();
    else        bt = q1.pop_front();
    checkOutput("sb_adr", s_adr, bt.adr);
    checkOutput("sb_we", 32'(s_we), 32'(bt.we));
    checkOutput("sb_sel", 32'(s_sel), 32'(bt.sel));
    checkOutput("sb_cti", 32'(s_cti), 32'(bt.cti));
    checkOutput("sb_bte", 32'(s_bte), 32'(bt.bte));
    if (bt.we) checkOutput("sb_wdata", 32'(s_dat_ms), 32'(bt.dat));
    else       checkOutput("sb_rdata", 32'(rd), 32'(slave_data(bt.adr)));
  endtask

  // Slave model: acks a strobed beat after a random number of wait states,
  // can stall forever, or can drive a stray ack while nobody owns the bus.
  always begin
    @(posedge clk);
    #2;
    if (s_cyc && s_stb && !slv_hold) begin
      if (!slv_busy) begin
        slv_busy = 1'b1;
        slv_wait = $urandom_range(slv_max, slv_min);
      end
      if (slv_wait == 0) begin
        s_ack    = 1'b1;
        s_dat_sm = slave_data(s_adr);
        slv_busy = 1'b0;
      end else begin
        s_ack = 1'b0;
        slv_wait--;
      end
    end else begin
      s_ack    = slv_spurious;
      s_dat_sm = 16'h0000;
      slv_busy = 1'b0;
    end
  end

  int          own = -1;
  logic        last_srv = 1'b1;
  logic        p_rst = 1'b1;
  logic        p_cyc0 = 1'b0;
  logic        p_cyc1 = 1'b0;
  logic [1:0]  p_gnt = 2'b00;
  logic [1:0]  exp_gnt;

  // Monitor: advances the round-robin reference from last cycle's requests,
  // compares grant/muxing/ack routing, and retires scoreboard beats on ack.
  always @(negedge clk) begin
    if (p_rst) begin
      own = -1;
      last_srv = 1'b1;
    end else if (own < 0) begin
      if (p_cyc0 && p_cyc1) own = last_srv ? 0 : 1;
      else if (p_cyc0)      own = 0;
      else if (p_cyc1)      own = 1;
    end else if (!((own == 0) ? p_cyc0 : p_cyc1)) begin
      last_srv = (own == 1);
      if (own == 0 && p_cyc1)      own = 1;
      else if (own == 1 && p_cyc0) own = 0;
      else                         own = -1;
    end
    exp_gnt = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
    checkOutput("gnt", 32'(gnt), 32'(exp_gnt));
    checkOutput("s_cyc", 32'(s_cyc), 32'((own >= 0) ? mcyc[own] : 1'b0));
    checkOutput("s_stb", 32'(s_stb), 32'((own >= 0) ? mstb[own] : 1'b0));
    checkOutput("m0_ack", 32'(m0_ack), 32'(own == 0 && s_ack));
    checkOutput("m1_ack", 32'(m1_ack), 32'(own == 1 && s_ack));
    if (m0_ack) begin
      ack_cnt[0]++;
      alog.push_back(0);
      last_rd[0] = m0_dat_sm;
      popBeat(0, m0_dat_sm);
    end
    if (m1_ack) begin
      ack_cnt[1]++;
      alog.push_back(1);
      last_rd[1] = m1_dat_sm;
      popBeat(1, m1_dat_sm);
    end
    if (gnt != 2'b00 && gnt != p_gnt) glog.push_back((gnt == 2'b10) ? 1 : 0);
    p_rst  = rst;
    p_cyc0 = mcyc[0];
    p_cyc1 = mcyc[1];
    p_gnt  = gnt;
  end

  // Hard stop in case something wedges the bench itself.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: actual=still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  int c0, c1, lead;

  // Directed scenarios followed by a randomized mixed-traffic run.
  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mcyc[i] = 1'b0; mstb[i] = 1'b0; mwe[i] = 1'b0; madr[i] = 32'h0;
      mdat[i] = 16'h0; msel[i] = 2'b00; mcti[i] = 3'b000; mbte[i] = 2'b00;
      ack_cnt[i] = 0; last_rd[i] = 16'h0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_gnt", 32'(gnt), 32'h0);
    checkOutput("reset_s_cyc", 32'(s_cyc), 32'h0);
    checkOutput("reset_s_stb", 32'(s_stb), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(2);

    $display("[TB] single master read");
    slv_min = 2; slv_max = 2;
    c0 = ack_cnt[0]; c1 = ack_cnt[1];
    fork
      applyStimulus(0, 32'h0000_0100, 1, 1'b0, 1'b0);
      begin
        @(negedge clk);
        checkOutput("t1_s_cyc_same_cycle", 32'(s_cyc), 32'h0);
        @(negedge clk);
        checkOutput("t1_s_cyc_next_cycle", 32'(s_cyc), 32'h1);
      end
    join
    checkOutput("t1_m0_acks", 32'(ack_cnt[0] - c0), 32'd1);
    checkOutput("t1_m1_acks", 32'(ack_cnt[1] - c1), 32'd0);
    checkOutput("t1_m0_data", 32'(last_rd[0]), 32'hBEEF);

    $display("[TB] contention after reset");
    @(posedge clk); #1; rst = 1'b1;
    tick(1); rst = 1'b0;
    tick(2);
    slv_min = 0; slv_max = 2;
    glog.delete();
    fork
      applyStimulus(0, 32'h0000_0200, 1, 1'b0, 1'b1);
      applyStimulus(1, 32'h0000_0300, 1, 1'b0, 1'b0);
    join
    checkOutput("t2_grants", 32'(glog.size()), 32'd2);
    checkOutput("t2_first", 32'(glog[0]), 32'd0);
    checkOutput("t2_second", 32'(glog[1]), 32'd1);

    $display("[TB] round-robin fairness");
    slv_min = 0; slv_max = 1;
    glog.delete();
    c0 = ack_cnt[0]; c1 = ack_cnt[1];
    fork
      begin
        for (int k = 0; k < 4; k++) applyStimulus(0, 32'h0000_1000 + 32'(k * 16), 4, 1'b1, 1'b0);
      end
      begin
        for (int k = 0; k < 4; k++) applyStimulus(1, 32'h0000_2000 + 32'(k * 16), 4, 1'b1, 1'b1);
      end
    join
    checkOutput("t3_grants", 32'(glog.size()), 32'd8);
    for (int i = 1; i < glog.size(); i++)
      checkOutput("t3_alternate", 32'(glog[i] != glog[i-1]), 32'd1);
    checkOutput("t3_m0_acks", 32'(ack_cnt[0] - c0), 32'd16);
    checkOutput("t3_m1_acks", 32'(ack_cnt[1] - c1), 32'd16);

    $display("[TB] burst integrity");
    tick(2);
    alog.delete();
    fork
      applyStimulus(1, 32'h0000_4000, 8, 1'b1, 1'b0);
      begin
        tick(3);
        applyStimulus(0, 32'h0000_5000, 1, 1'b0, 1'b1);
      end
    join
    lead = 0;
    while (lead < alog.size() && alog[lead] == 1) lead++;
    checkOutput("t4_m1_leading_acks", 32'(lead), 32'd8);
    checkOutput("t4_total_acks", 32'(alog.size()), 32'd9);

    $display("[TB] reset mid-transfer");
    tick(2);
    slv_hold = 1'b1;
    mcyc[1] = 1'b1; mstb[1] = 1'b1; mwe[1] = 1'b0; madr[1] = 32'h0000_6000; mcti[1] = 3'b000;
    tick(2);
    @(negedge clk);
    checkOutput("t5_pre_gnt", 32'(gnt), 32'h2);
    @(posedge clk); #1;
    rst = 1'b1;
    mcyc[0] = 1'b1; mstb[0] = 1'b1; mwe[0] = 1'b0; madr[0] = 32'h0000_7000; mcti[0] = 3'b000;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t5_s_cyc_after_rst", 32'(s_cyc), 32'h0);
    checkOutput("t5_gnt_after_rst", 32'(gnt), 32'h0);
    @(negedge clk);
    checkOutput("t5_m0_first", 32'(gnt), 32'h1);
    @(posedge clk); #1;
    mcyc[0] = 1'b0; mstb[0] = 1'b0; mcyc[1] = 1'b0; mstb[1] = 1'b0;
    slv_hold = 1'b0;
    tick(3);

    $display("[TB] spurious ack while idle");
    slv_spurious = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t6_m0_ack", 32'(m0_ack), 32'h0);
      checkOutput("t6_m1_ack", 32'(m1_ack), 32'h0);
      checkOutput("t6_gnt", 32'(gnt), 32'h0);
    end
    @(posedge clk); #1;
    slv_spurious = 1'b0;
    tick(2);

    $display("[TB] randomized traffic");
    slv_min = 0; slv_max = 2;
    fork
      begin
        for (int k = 0; k < 12; k++) begin
          logic bst;
          bst = 1'($urandom_range(1, 0));
          applyStimulus(0, {16'h0000, 16'($urandom)} & 32'hFFFF_FFFE, bst ? 4 : 1, bst,
                        1'($urandom_range(1, 0)));
          tick($urandom_range(3, 0));
        end
      end
      begin
        for (int k = 0; k < 12; k++) begin
          logic bst;
          bst = 1'($urandom_range(1, 0));
          applyStimulus(1, {16'h0001, 16'($urandom)} & 32'hFFFF_FFFE, bst ? 4 : 1, bst,
                        1'($urandom_range(1, 0)));
          tick($urandom_range(3, 0));
        end
      end
    join
    tick(3);
    checkOutput("end_q0_empty", 32'(q0.size()), 32'd0);
    checkOutput("end_q1_empty", 32'(q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
